// File: rtl/frame_collector.sv
// frame_collector: gathers the decoded tag bit stream into one fixed-length frame and
// presents it in parallel with a one-cycle valid pulse. Frames that stall mid-stream are
// aborted with a one-cycle error pulse.
// Optional feature: define CRC16_CHECK_EN to build the trailing EPC Gen2 CRC-16 residue
// check; without it out_crc_ok is tied to 0.
module frame_collector #(
  parameter int unsigned MAX_BITS  = 128,
  parameter int unsigned LEN_WIDTH = $clog2(MAX_BITS + 1),
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TO_WIDTH  = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_dat,
  input  logic                 in_vld,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic [MAX_BITS-1:0]  out_frame,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_vld,
  output logic                 out_crc_ok,
  output logic                 out_err,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e               state;
  logic [LEN_WIDTH-1:0] count;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic [LEN_WIDTH-1:0] len_lim;
  logic                 start;
  logic                 accept;
  logic                 last_bit;
  logic                 crc_pass;

  // Frame start/accept decode; out_len doubles as the latched frame length L.
  always_comb begin
    len_lim  = (frame_len > LEN_WIDTH'(MAX_BITS)) ? LEN_WIDTH'(MAX_BITS) : frame_len;
    start    = in_vld && (frame_len != '0) && (state != StCollect);
    accept   = in_vld && (state == StCollect);
    last_bit = (LEN_WIDTH'(count + 1'b1) == out_len);
  end

  assign busy = (state == StCollect);

`ifdef CRC16_CHECK_EN
  logic [15:0] crc;
  logic [15:0] crc_seed;
  logic [15:0] crc_next;

  // Serial CRC-16/CCITT step; the preset is folded in when a frame starts.
  always_comb begin
    crc_seed = start ? 16'hFFFF : crc;
    crc_next = {crc_seed[14:0], 1'b0} ^ ((crc_seed[15] ^ in_dat) ? 16'h1021 : 16'h0000);
    crc_pass = (out_len >= LEN_WIDTH'(16)) && (crc_next == 16'h1D0F);
  end

  // CRC register advances on every accepted bit, CRC field included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= '0;
    end else if (start || accept) begin
      crc <= crc_next;
    end
  end
`else
  assign crc_pass = 1'b0;
`endif

  // Frame FSM with registered outputs; DONE accepts the next frame's first bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      out_frame  <= '0;
      out_len    <= '0;
      out_vld    <= 1'b0;
      out_crc_ok <= 1'b0;
      out_err    <= 1'b0;
      count      <= '0;
      to_cnt     <= '0;
    end else begin
      out_vld <= 1'b0;
      out_err <= 1'b0;
      case (state)
        StIdle, StDone: begin
          if (start) begin
            out_len    <= len_lim;
            out_frame  <= {{(MAX_BITS - 1){1'b0}}, in_dat};
            count      <= LEN_WIDTH'(1);
            to_cnt     <= '0;
            out_crc_ok <= 1'b0;
            if (len_lim == LEN_WIDTH'(1)) begin
              state   <= StDone;
              out_vld <= 1'b1;
            end else begin
              state <= StCollect;
            end
          end else begin
            state <= StIdle;
          end
        end
        StCollect: begin
          if (accept) begin
            out_frame <= {out_frame[MAX_BITS-2:0], in_dat};
            count     <= LEN_WIDTH'(count + 1'b1);
            to_cnt    <= '0;
            if (last_bit) begin
              state      <= StDone;
              out_vld    <= 1'b1;
              out_crc_ok <= crc_pass;
            end
          end else if (to_cnt == TO_WIDTH'(TIMEOUT - 1)) begin
            // Stalled frame: drop it without a valid pulse.
            out_err   <= 1'b1;
            out_frame <= '0;
            count     <= '0;
            to_cnt    <= '0;
            state     <= StIdle;
          end else begin
            to_cnt <= TO_WIDTH'(to_cnt + 1'b1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
